prio_irq_ctrl: RTL and testbench
================================

Name: prio_irq_ctrl

Overview:
- Parametrised, registered interrupt controller and successor to the combinational priority selector.
- Captures request edges from N_SRC sources into a pending register and masks them.
- Arbitrates by per-source programmable priority in one of two modes: fixed or round-robin tie-break.
- Presents one winner through a request/acknowledge/end-of-interrupt handshake to the CPU-side control unit.

Parameters:
- N_SRC, 16, number of interrupt sources (2..64).
- PRIO_W, 2, bits of priority per source; larger value means higher priority.
- ID_W, $clog2(N_SRC), width of the source index.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  tie-break mode: 0 = fixed (lowest index wins), 1 = round-robin.
- irq_req  in  N_SRC  level request lines; a rising edge is captured.
- prio  in  N_SRC*PRIO_W  priority of source i in bits [PRIO_W*i+PRIO_W-1 : PRIO_W*i].
- mask  in  N_SRC  enable per source; 1 = eligible.
- ack  in  1  CPU accepts the presented interrupt.
- eoi  in  1  CPU finished servicing.
- irq_out  out  1  interrupt presented.
- irq_id  out  ID_W  index of the presented or in-service source.
- irq_level  out  PRIO_W  priority of irq_id at capture time.
- busy  out  1  a source is in service.
- pending  out  N_SRC  pending register, for visibility.

Behaviour:
- Reset (synchronous): all outputs 0, pending 0, req_d 0, state IDLE, last_served = N_SRC-1 so round-robin starts at index 0. Reset beats every other input, including mid-handshake.
- Edge capture: req_d <= irq_req.
  - pending[i] <= (pending[i] & ~clr[i]) | (irq_req[i] & ~req_d[i]).
  - When set and clear hit the same bit in one cycle, set wins and the new edge is kept.
  - A held-high line produces one pending event only.
- Eligible set: pending & mask. Masking never clears pending.
- Arbitration (combinational over the eligible set):
  - The winner is the eligible source with the maximum prio value.
  - Ties, mode 0: lowest index.
  - Ties, mode 1: first index after last_served, modulo N_SRC.
  - A priority value of 0 is still eligible.
- States:
  - IDLE: if any source is eligible, register irq_id and irq_level from the winner, set irq_out = 1, go to REQ.
  - REQ: irq_id and irq_level are held stable.
    - If ack: clr[irq_id] = 1, last_served <= irq_id, irq_out <= 0, busy <= 1, go to SERVICE.
    - Else if mask[irq_id] == 0: withdraw, irq_out <= 0, go to IDLE; pending is kept.
    - ack takes precedence over a mask drop in the same cycle.
    - A higher-priority arrival during REQ does not replace the presented id.
  - SERVICE: busy = 1, irq_id is held. On eoi: busy <= 0, go to IDLE. No nesting or preemption.
- Ignored inputs: ack outside REQ, eoi outside SERVICE.
- Back-to-back service: the cycle eoi is taken returns to IDLE; the next irq_out rises one cycle later.
- Latency:
  - irq_req edge at cycle k → pending bit set after edge k+1 → irq_out high after edge k+2.
  - ack at cycle j → pending cleared and irq_out low after edge j+1.
- mode and prio are sampled only at arbitration in IDLE; changing them in REQ or SERVICE does not affect the current grant.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2) and the mode encodings MODE_FIXED and MODE_RR.
- One sub-module: prio_arbiter.
  - Purely combinational, parametrised by N_SRC and PRIO_W.
  - Inputs: eligible, prio, mode, last_served.
  - Outputs: any, win_id, win_level.
- The top level holds the edge capture, pending register and FSM.

Test Plan:
- Fixed priority, decoding check:
  - Stimulus: N_SRC=16, PRIO_W=2, mode=0, mask=FFFF, prio=32'h80CE00C0, pulse irq_req bits 6, 7 and 9 together.
  - Response: irq_out two cycles later with irq_id=9, irq_level=3.
  - After ack then eoi: id 6 presented (level 0, lowest index), then id 7.
- Round-robin ties:
  - Stimulus: mode=1, prio all 2'b01, edges on sources 2, 5 and 12.
  - Response: grant order 2, 5, 12.
  - Then re-raise 2 and 5 while 12 is in service; after eoi the order is 2, then 5 (wrap past last_served=12).
- Mask withdraw:
  - Stimulus: present id 4, drop mask[4] in REQ.
  - Response: irq_out=0 next cycle, pending[4] stays 1.
  - After restoring mask[4]: re-presented with id 4.
- Ack/edge collision: a new irq_req[3] edge in the same cycle as ack of id 3 → pending[3] remains 1, and id 3 is presented again after eoi.
- Ignored handshakes: ack in IDLE and SERVICE, eoi in REQ → no state change, pending unchanged.
- Reset mid-service: assert reset in SERVICE with pending=16'h0101.
  - Response: next cycle all outputs 0 and pending 0.
  - A held-high irq_req after reset counts as a new edge (req_d cleared) and is presented two cycles after reset releases.

Source files
------------

// File: rtl/prio_irq_ctrl_pkg.sv
// prio_irq_ctrl_pkg
// Shared definitions for the registered priority interrupt controller:
// handshake FSM state encoding and tie-break mode encodings.
package prio_irq_ctrl_pkg;

   // Handshake FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   // Tie-break modes applied among sources sharing the maximum priority
   localparam logic MODE_FIXED = 1'b0;   // lowest index wins
   localparam logic MODE_RR    = 1'b1;   // first index after last served wins

endpackage

// File: rtl/prio_irq_ctrl_prio_arbiter.sv
// prio_arbiter
// Purely combinational winner selection over the eligible set.
// Ports:
//   eligible    - pending & mask, one bit per source
//   prio        - packed per-source priorities, PRIO_W bits each
//   mode        - MODE_FIXED or MODE_RR tie-break
//   last_served - index most recently acknowledged (round-robin origin)
//   any         - at least one source is eligible
//   win_id      - index of the winning source
//   win_level   - priority of the winning source
module prio_arbiter
   import prio_irq_ctrl_pkg::*;
#(
   parameter int N_SRC  = 16,
   parameter int PRIO_W = 2,
   parameter int ID_W   = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0]        eligible,
   input  logic [N_SRC*PRIO_W-1:0] prio,
   input  logic                    mode,
   input  logic [ID_W-1:0]         last_served,
   output logic                    any,
   output logic [ID_W-1:0]         win_id,
   output logic [PRIO_W-1:0]       win_level
);

   localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_SRC);

   logic [ID_W:0]     start_raw_s;
   logic [ID_W:0]     start_s;
   logic [ID_W:0]     idx_raw_s;
   logic [ID_W:0]     idx_s;
   logic [PRIO_W-1:0] lvl_s;

   // Scan sources in tie-break order starting at start_s; a strictly greater
   // priority replaces the current best, so the first source at the maximum
   // level in scan order wins the tie.
   always_comb begin
      any       = 1'b0;
      win_id    = '0;
      win_level = '0;
      idx_raw_s = '0;
      idx_s     = '0;
      lvl_s     = '0;
      if (mode == MODE_RR) begin
         start_raw_s = {1'b0, last_served} + (ID_W+1)'(1);
      end else begin
         start_raw_s = '0;
      end
      start_s = (start_raw_s >= N_EXT) ? (start_raw_s - N_EXT) : start_raw_s;
      for (int k = 0; k < N_SRC; k++) begin
         idx_raw_s = start_s + (ID_W+1)'(k);
         idx_s     = (idx_raw_s >= N_EXT) ? (idx_raw_s - N_EXT) : idx_raw_s;
         lvl_s     = prio[int'(idx_s)*PRIO_W +: PRIO_W];
         if (eligible[idx_s[ID_W-1:0]] && (!any || (lvl_s > win_level))) begin
            any       = 1'b1;
            win_id    = idx_s[ID_W-1:0];
            win_level = lvl_s;
         end else begin
            any       = any;
         end
      end
   end

endmodule

// File: rtl/prio_irq_ctrl.sv
// prio_irq_ctrl
// Registered interrupt controller: captures rising request edges into a
// pending register, arbitrates the masked set by priority, and presents one
// winner through a request / acknowledge / end-of-interrupt handshake.
// Ports:
//   clock, reset - rising-edge clock, synchronous active-high reset
//   mode         - tie-break mode (MODE_FIXED / MODE_RR)
//   irq_req      - level request lines, rising edge captured
//   prio         - packed per-source priorities
//   mask         - per-source enable (1 = eligible)
//   ack, eoi     - CPU accept and end-of-service strobes
//   irq_out      - interrupt presented
//   irq_id       - presented / in-service source index
//   irq_level    - priority of irq_id captured at arbitration
//   busy         - a source is in service
//   pending      - pending register
module prio_irq_ctrl
   import prio_irq_ctrl_pkg::*;
#(
   parameter int N_SRC  = 16,
   parameter int PRIO_W = 2,
   parameter int ID_W   = $clog2(N_SRC)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [N_SRC-1:0]        irq_req,
   input  logic [N_SRC*PRIO_W-1:0] prio,
   input  logic [N_SRC-1:0]        mask,
   input  logic                    ack,
   input  logic                    eoi,
   output logic                    irq_out,
   output logic [ID_W-1:0]         irq_id,
   output logic [PRIO_W-1:0]       irq_level,
   output logic                    busy,
   output logic [N_SRC-1:0]        pending
);

   // Round-robin origin after reset: the last index, so index 0 is first
   localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N_SRC-1);

   state_e            state_q, state_d;
   logic [N_SRC-1:0]  req_q;
   logic [N_SRC-1:0]  pending_q, pending_d;
   logic [N_SRC-1:0]  clr_s;
   logic              irq_out_q, irq_out_d;
   logic [ID_W-1:0]   irq_id_q, irq_id_d;
   logic [PRIO_W-1:0] irq_level_q, irq_level_d;
   logic              busy_q, busy_d;
   logic [ID_W-1:0]   last_served_q, last_served_d;

   logic              arb_any_s;
   logic [ID_W-1:0]   arb_id_s;
   logic [PRIO_W-1:0] arb_level_s;

   prio_arbiter #(
      .N_SRC  (N_SRC),
      .PRIO_W (PRIO_W),
      .ID_W   (ID_W)
   ) u_arbiter (
      .eligible    (pending_q & mask),
      .prio        (prio),
      .mode        (mode),
      .last_served (last_served_q),
      .any         (arb_any_s),
      .win_id      (arb_id_s),
      .win_level   (arb_level_s)
   );

   // Handshake FSM next state and output/pending next values
   always_comb begin
      state_d       = state_q;
      irq_out_d     = irq_out_q;
      irq_id_d      = irq_id_q;
      irq_level_d   = irq_level_q;
      busy_d        = busy_q;
      last_served_d = last_served_q;
      clr_s         = '0;
      case (state_q)
         IDLE: begin
            // mode and prio only matter here; the grant is latched
            if (arb_any_s) begin
               irq_id_d    = arb_id_s;
               irq_level_d = arb_level_s;
               irq_out_d   = 1'b1;
               state_d     = REQ;
            end else begin
               state_d     = IDLE;
            end
         end
         REQ: begin
            // ack outranks a simultaneous mask drop
            if (ack) begin
               clr_s[irq_id_q] = 1'b1;
               last_served_d   = irq_id_q;
               irq_out_d       = 1'b0;
               busy_d          = 1'b1;
               state_d         = SERVICE;
            end else if (!mask[irq_id_q]) begin
               // withdraw; the pending bit survives for later
               irq_out_d       = 1'b0;
               state_d         = IDLE;
            end else begin
               state_d         = REQ;
            end
         end
         SERVICE: begin
            if (eoi) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = SERVICE;
            end
         end
         default: begin
            irq_out_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
      endcase
      // A new edge on a bit being cleared is kept (set wins)
      pending_d = (pending_q & ~clr_s) | (irq_req & ~req_q);
   end

   // State, edge-detect history, pending and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         req_q         <= '0;
         pending_q     <= '0;
         irq_out_q     <= 1'b0;
         irq_id_q      <= '0;
         irq_level_q   <= '0;
         busy_q        <= 1'b0;
         last_served_q <= LAST_INIT;
      end else begin
         state_q       <= state_d;
         req_q         <= irq_req;
         pending_q     <= pending_d;
         irq_out_q     <= irq_out_d;
         irq_id_q      <= irq_id_d;
         irq_level_q   <= irq_level_d;
         busy_q        <= busy_d;
         last_served_q <= last_served_d;
      end
   end

   assign irq_out   = irq_out_q;
   assign irq_id    = irq_id_q;
   assign irq_level = irq_level_q;
   assign busy      = busy_q;
   assign pending   = pending_q;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// tb_prio_irq_ctrl
// Directed self-checking bench for prio_irq_ctrl with N_SRC=16, PRIO_W=2.
module tb_prio_irq_ctrl;

   localparam int N_SRC  = 16;
   localparam int PRIO_W = 2;
   localparam int ID_W   = 4;

   logic                    clock;
   logic                    reset;
   logic                    mode;
   logic [N_SRC-1:0]        irq_req;
   logic [N_SRC*PRIO_W-1:0] prio;
   logic [N_SRC-1:0]        mask;
   logic                    ack;
   logic                    eoi;
   logic                    irq_out;
   logic [ID_W-1:0]         irq_id;
   logic [PRIO_W-1:0]       irq_level;
   logic                    busy;
   logic [N_SRC-1:0]        pending;

   int errors = 0;
   int checks = 0;

   prio_irq_ctrl #(
      .N_SRC  (N_SRC),
      .PRIO_W (PRIO_W),
      .ID_W   (ID_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .mode      (mode),
      .irq_req   (irq_req),
      .prio      (prio),
      .mask      (mask),
      .ack       (ack),
      .eoi       (eoi),
      .irq_out   (irq_out),
      .irq_id    (irq_id),
      .irq_level (irq_level),
      .busy      (busy),
      .pending   (pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ack then eoi, one cycle each
   task automatic serve();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      mode    = 1'b0;
      irq_req = '0;
      prio    = '0;
      mask    = '0;
      ack     = 1'b0;
      eoi     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_irq_out", irq_out, 0);
      check("rst_irq_id", irq_id, 0);
      check("rst_level", irq_level, 0);
      check("rst_busy", busy, 0);
      check("rst_pending", pending, 0);

      // ---- fixed priority decode: 6,7 at level 0, 9 at level 3
      mode    = 1'b0;
      mask    = 16'hFFFF;
      prio    = 32'h80CE00C0;
      irq_req = 16'h02C0;
      tick();
      check("fx_pending_set", pending, 16'h02C0);
      check("fx_not_yet", irq_out, 0);
      irq_req = 16'h0000;
      tick();
      check("fx_irq_out", irq_out, 1);
      check("fx_id9", irq_id, 9);
      check("fx_level3", irq_level, 3);
      // eoi in REQ is ignored
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("ign_eoi_req_out", irq_out, 1);
      check("ign_eoi_req_busy", busy, 0);
      check("ign_eoi_req_pend", pending, 16'h02C0);
      ack = 1'b1;
      tick();
      check("fx_ack_out", irq_out, 0);
      check("fx_ack_busy", busy, 1);
      check("fx_ack_pend", pending, 16'h00C0);
      check("fx_ack_id_held", irq_id, 9);
      // ack held into SERVICE is ignored
      tick();
      ack = 1'b0;
      check("ign_ack_svc_busy", busy, 1);
      check("ign_ack_svc_pend", pending, 16'h00C0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("fx_eoi_busy", busy, 0);
      check("fx_eoi_out", irq_out, 0);
      tick();
      check("fx_second_out", irq_out, 1);
      check("fx_id6", irq_id, 6);
      check("fx_level0", irq_level, 0);
      serve();
      tick();
      check("fx_id7", irq_id, 7);
      check("fx_id7_out", irq_out, 1);
      serve();
      check("fx_drained", pending, 0);
      // ack in IDLE is ignored
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ign_ack_idle_out", irq_out, 0);
      check("ign_ack_idle_busy", busy, 0);
      check("ign_ack_idle_pend", pending, 0);

      // ---- round-robin ties from a fresh reset
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      mode    = 1'b1;
      prio    = 32'h55555555;
      irq_req = 16'h1024;
      tick();
      irq_req = 16'h0000;
      tick();
      check("rr_first_id2", irq_id, 2);
      serve();
      tick();
      check("rr_second_id5", irq_id, 5);
      serve();
      tick();
      check("rr_third_id12", irq_id, 12);
      ack = 1'b1;
      tick();
      ack     = 1'b0;
      irq_req = 16'h0024;
      tick();
      irq_req = 16'h0000;
      tick();
      check("rr_reraise_pend", pending, 16'h0024);
      check("rr_svc_busy", busy, 1);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      tick();
      check("rr_wrap_id2", irq_id, 2);
      serve();
      tick();
      check("rr_wrap_id5", irq_id, 5);
      serve();

      // ---- mask withdraw and ack-over-mask-drop
      mode    = 1'b0;
      prio    = '0;
      irq_req = 16'h0010;
      tick();
      irq_req = 16'h0000;
      tick();
      check("mk_present", irq_out, 1);
      check("mk_id4", irq_id, 4);
      mask = 16'hFFEF;
      tick();
      check("mk_withdraw_out", irq_out, 0);
      check("mk_pend_kept", pending, 16'h0010);
      tick();
      check("mk_stay_idle", irq_out, 0);
      mask = 16'hFFFF;
      tick();
      check("mk_represent", irq_out, 1);
      check("mk_represent_id", irq_id, 4);
      ack  = 1'b1;
      mask = 16'hFFEF;
      tick();
      ack  = 1'b0;
      mask = 16'hFFFF;
      check("mk_ack_wins_busy", busy, 1);
      check("mk_ack_wins_pend", pending, 0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;

      // ---- new edge colliding with ack of the same source
      irq_req = 16'h0008;
      tick();
      irq_req = 16'h0000;
      tick();
      check("col_id3", irq_id, 3);
      ack     = 1'b1;
      irq_req = 16'h0008;
      tick();
      ack     = 1'b0;
      irq_req = 16'h0000;
      check("col_pend_kept", pending, 16'h0008);
      check("col_busy", busy, 1);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      tick();
      check("col_again_out", irq_out, 1);
      check("col_again_id", irq_id, 3);
      serve();

      // ---- reset during SERVICE with held-high requests
      prio    = 32'h00010000;
      irq_req = 16'h0002;
      tick();
      irq_req = 16'h0000;
      tick();
      ack = 1'b1;
      tick();
      ack     = 1'b0;
      irq_req = 16'h0101;
      tick();
      check("rs_pre_pend", pending, 16'h0101);
      check("rs_pre_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rs_out0", irq_out, 0);
      check("rs_id0", irq_id, 0);
      check("rs_busy0", busy, 0);
      check("rs_pend0", pending, 0);
      tick();
      check("rs_edge_pend", pending, 16'h0101);
      check("rs_edge_noout", irq_out, 0);
      tick();
      check("rs_present_out", irq_out, 1);
      check("rs_present_id8", irq_id, 8);
      check("rs_present_lvl1", irq_level, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
